// File: rtl/logit_pwl.sv
// Piecewise-linear logit: x = ln(p/(1-p)) in Q6.9, 3-stage valid/ready pipeline.
// Optional LOGIT_ROUND_EN: round half up on the interpolation shift instead of truncating.
module logit_pwl #(
    parameter logic [15:0] SAT_POS = 16'h1000,
    parameter logic [15:0] SAT_NEG = 16'hF000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] p_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x_out
);

    localparam int unsigned DW    = 16;
    localparam int unsigned PRODW = 18;
    localparam logic [DW-1:0] P_ONE  = 16'h0200;
    localparam logic [DW-1:0] P_HALF = 16'h0100;

    typedef enum logic [1:0] {
        TAG_NORM = 2'd0,
        TAG_SATN = 2'd1,
        TAG_SATP = 2'd2,
        TAG_ZERO = 2'd3
    } tag_e;

    // Knot values L_k = logit(2^k/512)
    function automatic logic [DW-1:0] lut_l(input logic [2:0] k);
        logic [DW-1:0] r;
        case (k)
            3'd0:    r = 16'hF387;
            3'd1:    r = 16'hF4EB;
            3'd2:    r = 16'hF650;
            3'd3:    r = 16'hF7B7;
            3'd4:    r = 16'hF922;
            3'd5:    r = 16'hFA95;
            3'd6:    r = 16'hFC1C;
            default: r = 16'hFDCE;
        endcase
        return r;
    endfunction

    // Segment slopes D_k = L_(k+1) - L_k
    function automatic logic [9:0] lut_d(input logic [2:0] k);
        logic [9:0] r;
        case (k)
            3'd0:    r = 10'd356;
            3'd1:    r = 10'd357;
            3'd2:    r = 10'd359;
            3'd3:    r = 10'd363;
            3'd4:    r = 10'd371;
            3'd5:    r = 10'd391;
            3'd6:    r = 10'd434;
            default: r = 10'd562;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] lead_one(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    logic              v1_q, v2_q, v3_q;
    tag_e              tag1_q, tag2_q;
    logic              neg1_q, neg2_q;
    logic [2:0]        k1_q, k2_q;
    logic [7:0]        off1_q;
    logic [PRODW-1:0]  prod2_q;
    logic [DW-1:0]     x_out_q;

    logic              ld1, ld2, ld3;
    tag_e              tag1_d;
    logic              neg1_d;
    logic [2:0]        k1_d;
    logic [7:0]        off1_d;
    logic [8:0]        q_c;
    logic [PRODW-1:0]  prod2_d;
    logic [DW-1:0]     x3_d;

    // A stage accepts when empty or when its successor is taking its contents
    assign ld3       = ~v3_q | out_ready;
    assign ld2       = ~v2_q | ld3;
    assign ld1       = ~v1_q | ld2;
    assign in_ready  = ld1;
    assign out_valid = v3_q;
    assign x_out     = x_out_q;

    // S1: classify, fold upper half onto lower half, locate segment
    always_comb begin
        tag1_d = TAG_NORM;
        neg1_d = 1'b0;
        k1_d   = 3'd0;
        off1_d = 8'd0;
        q_c    = 9'd0;
        if ($signed(p_in) <= $signed(16'sd0)) begin
            tag1_d = TAG_SATN;
        end else if ($signed(p_in) >= $signed(P_ONE)) begin
            tag1_d = TAG_SATP;
        end else begin
            neg1_d = (p_in > P_HALF);
            q_c    = neg1_d ? 9'(P_ONE - p_in) : p_in[8:0];
            if (q_c[8]) begin
                tag1_d = TAG_ZERO;
            end else begin
                k1_d   = lead_one(q_c[7:0]);
                off1_d = q_c[7:0] - (8'd1 << k1_d);
            end
        end
    end

    // S2: slope times offset within the segment
    assign prod2_d = PRODW'(lut_d(k1_q)) * PRODW'(off1_q);

    // S3: scale back by segment width, add knot, unfold sign, apply tags
    always_comb begin
        logic [PRODW-1:0] biased;
        logic [DW-1:0]    m;
        biased = prod2_q;
`ifdef LOGIT_ROUND_EN
        if (k2_q != 3'd0) biased = prod2_q + (PRODW'(1) << 3'(k2_q - 3'd1));
`endif
        m    = lut_l(k2_q) + DW'(biased >> k2_q);
        x3_d = neg2_q ? DW'(16'd0 - m) : m;
        case (tag2_q)
            TAG_SATN: x3_d = SAT_NEG;
            TAG_SATP: x3_d = SAT_POS;
            TAG_ZERO: x3_d = 16'h0000;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            tag1_q  <= TAG_NORM;
            tag2_q  <= TAG_NORM;
            neg1_q  <= 1'b0;
            neg2_q  <= 1'b0;
            k1_q    <= 3'd0;
            k2_q    <= 3'd0;
            off1_q  <= 8'd0;
            prod2_q <= '0;
            x_out_q <= '0;
        end else begin
            if (ld1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    tag1_q <= tag1_d;
                    neg1_q <= neg1_d;
                    k1_q   <= k1_d;
                    off1_q <= off1_d;
                end
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    tag2_q  <= tag1_q;
                    neg2_q  <= neg1_q;
                    k2_q    <= k1_q;
                    prod2_q <= prod2_d;
                end
            end
            if (ld3) begin
                v3_q <= v2_q;
                if (v2_q) x_out_q <= x3_d;
            end
        end
    end

endmodule
